oled_spi_rx: RTL
================

# oled_spi_rx

SPI receiver/decoder for the SSD1331 OLED write stream (96x64, RGB565). Oversamples `oled_csn/oled_clk/oled_mosi/oled_dc/oled_resn` in the system clock domain and reassembles command bytes and pixel writes with their screen coordinates. It is the far end of the OLED video transmitter. It is used as a display emulator in simulation and as a bus sniffer on hardware, for example feeding a framebuffer or an HDMI mirror.

## Interface
Parameters:
- `C_x_size`, 96, display columns; `px_x` wraps at `C_x_size-1`.
- `C_y_size`, 64, display rows; `px_y` wraps at `C_y_size-1`.

Ports:
- `clk` in 1: system clock. Must be at least 4x the `oled_clk` frequency, with `oled_clk` high and low each lasting at least 2 `clk` periods.
- `reset` in 1: synchronous, active-high reset.
- `oled_csn` in 1: chip select, active low (asynchronous input).
- `oled_clk` in 1: SPI clock; data is sampled on its rising edge (asynchronous input).
- `oled_mosi` in 1: serial data, MSB first (asynchronous input).
- `oled_dc` in 1: 0 = command/argument byte, 1 = pixel data byte (asynchronous input).
- `oled_resn` in 1: display reset, active low (asynchronous input).
- `cmd_valid` out 1: one-cycle strobe for each DC=0 byte.
- `cmd_data` out 8: the command or argument byte.
- `px_valid` out 1: one-cycle strobe for each completed pixel.
- `px_x` out 7: column of the pixel.
- `px_y` out 6: row of the pixel.
- `px_color` out 16: pixel colour, RGB565 (`{r5,g6,b5}`).
- `frame_end` out 1: asserted together with `px_valid` for the pixel at (col_end, row_end).

## Operation
- **Synchronisers.** Each SPI input passes through a 2-flop synchroniser, plus a third flop on `oled_clk` for rising-edge detection.
- **Byte assembly.**
  - `oled_csn` high clears the bit counter and discards any partial byte.
  - Each `oled_clk` rising edge with `oled_csn` low shifts `oled_mosi` in, MSB first.
  - On the 8th bit, the byte is tagged with the current `oled_dc` and issued.
- **DC=0 bytes.**
  - `cmd_valid` pulses with the byte in `cmd_data`.
  - The pixel phase resets to the high byte.
  - The byte then goes to the command FSM (window mode only).
- **DC=1 bytes.**
  - The first byte is the high byte (`RRRRRGGG`); the second is the low byte (`GGGBBBBB`).
  - On the second byte, `px_valid` pulses with `px_color = {hi,lo}` and the current `px_x`/`px_y`; the pixel phase toggles.
- **Address advance after each pixel:**
  - `x` is `col_start` if `x==col_end`, otherwise 0 if `x==C_x_size-1`, otherwise `x+1`.
  - `y` advances only when `x==col_end`, using the same rule with `row_start`/`row_end`/`C_y_size`.
- **Functional reset.** Synchronised `oled_resn` low has the same effect as `reset`: it clears the FSM, bit counter and pixel phase and restores the window to full screen.
- **Command FSM states:** `S_CMD`, `S_COL_S`, `S_COL_E`, `S_ROW_S`, `S_ROW_E`.
  - `S_CMD`: byte 0x15 goes to `S_COL_S`; byte 0x75 goes to `S_ROW_S`; any other byte stays in `S_CMD`.
  - `S_COL_S`: stores `col_start` and goes to `S_COL_E`.
  - `S_COL_E`: stores `col_end`, loads `x=col_start`, and returns to `S_CMD`.
  - `S_ROW_S`/`S_ROW_E`: same pattern for `row_start`/`row_end`, loading `y=row_start`.
  - Argument values are clamped to `C_x_size-1` / `C_y_size-1`.
  - Every DC=0 byte in `S_CMD` is interpreted as an opcode. Arguments of other commands equal to 0x15 or 0x75 are misdecoded; this is an accepted limitation.
  - A DC=1 byte received in a non-`S_CMD` state returns the FSM to `S_CMD`; that byte is still processed as pixel data.

## Timing
- **Reset values:**
  - all strobes 0
  - `cmd_data`=0, `px_x`=0, `px_y`=0, `px_color`=0
  - window (0, C_x_size-1, 0, C_y_size-1)
  - FSM in `S_CMD`, pixel phase high, bit count 0
- **Latency.** Let E0 be the `clk` edge at which synchroniser stage 1 first captures the 8th `oled_clk` high. The bit is shifted at E2, and `cmd_valid`/`px_valid` are high during the cycle after E3. Total latency is 3 `clk` edges.
- **Strobe width.** Strobes are exactly 1 cycle. Consecutive strobes are at least 16 `clk` cycles apart under the minimum SPI period.
- **Output hold.** `px_x`/`px_y`/`px_color`/`cmd_data` hold their values until the next strobe of the same kind.
- **Simultaneous events.**
  - `reset` or `oled_resn` low takes priority over a completing byte: no strobe is emitted in that cycle.
  - If `oled_csn` rises in the same cycle as the 8th edge, the byte completes.
- **Framing.** `oled_csn` toggling between bytes does not reset the pixel phase or the FSM.

## Configuration
- `OLED_RX_WINDOW_EN`:
  - Defined: the command FSM and 0x15/0x75 window tracking are compiled in.
  - Undefined: the window is fixed at full screen, no FSM is built, and all DC=0 bytes (including 0x15/0x75 and their arguments) only produce `cmd_valid`.
  - In both builds, `frame_end` fires at (C_x_size-1, C_y_size-1) for the default window.

## Test plan
- **Command bytes.** Reset, then send DC=0 bytes 0xAE, 0xA0 at clk/4 SPI. Expect two `cmd_valid` pulses with 0xAE, 0xA0; `px_valid` never asserts.
- **Pixel stream.** Send DC=1 bytes 0xF8,0x00,0x07,0xE0. Expect `px_valid`(0,0,0xF800) then `px_valid`(1,0,0x07E0).
- **Full-frame wrap.** Send 96*64 pixels. `frame_end` asserts only on (95,63); the next pixel is reported at (0,0).
- **Window (WINDOW_EN).**
  - Send 0x15,10,12,0x75,5,6 then 6 pixels. Coordinates are (10,5),(11,5),(12,5),(10,6),(11,6),(12,6); `frame_end` asserts on the 6th.
  - Send 0x15,200,250. Window clamps to col 95..95.
- **Mid-byte abort.** Send 4 bits, raise `oled_csn`, then send a full DC=0 0x3C. Exactly one `cmd_valid`, with 0x3C.
- **Functional reset.** Send 1 pixel byte, then assert `oled_resn` low for 4 cycles, then send 0x12,0x34 DC=1. Expect `px_valid`(0,0,0x1234).

Source files
------------

// File: rtl/oled_spi_rx.sv
// SSD1331 SPI write-stream receiver: rebuilds command bytes and RGB565 pixels.
// Define OLED_RX_WINDOW_EN to track 0x15/0x75 column/row window commands.
module oled_spi_rx #(
  parameter int C_x_size = 96,
  parameter int C_y_size = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        oled_csn,
  input  logic        oled_clk,
  input  logic        oled_mosi,
  input  logic        oled_dc,
  input  logic        oled_resn,
  output logic        cmd_valid,
  output logic [7:0]  cmd_data,
  output logic        px_valid,
  output logic [6:0]  px_x,
  output logic [5:0]  px_y,
  output logic [15:0] px_color,
  output logic        frame_end
);

  localparam logic [6:0] XMAX = 7'(C_x_size - 1);
  localparam logic [5:0] YMAX = 6'(C_y_size - 1);

  logic [1:0] csn_q, mosi_q, dc_q, resn_q;
  logic [2:0] sck_q;
  logic       rise, frst;

  always_ff @(posedge clk) begin
    if (reset) begin
      csn_q  <= 2'b11;
      mosi_q <= '0;
      dc_q   <= '0;
      resn_q <= 2'b11;
      sck_q  <= '0;
    end else begin
      csn_q  <= {csn_q[0], oled_csn};
      mosi_q <= {mosi_q[0], oled_mosi};
      dc_q   <= {dc_q[0], oled_dc};
      resn_q <= {resn_q[0], oled_resn};
      sck_q  <= {sck_q[1:0], oled_clk};
    end
  end

  assign rise = sck_q[1] & ~sck_q[2];
  assign frst = reset | ~resn_q[1];

  logic [2:0] bcnt_q;
  logic [6:0] sr_q;
  logic       byte_v_q, byte_dc_q;
  logic [7:0] byte_q;

  // The 8th edge completes even if csn rises alongside it.
  always_ff @(posedge clk) begin
    if (frst) begin
      bcnt_q    <= '0;
      sr_q      <= '0;
      byte_v_q  <= 1'b0;
      byte_dc_q <= 1'b0;
      byte_q    <= '0;
    end else begin
      byte_v_q <= 1'b0;
      if (rise && (!csn_q[1] || bcnt_q == 3'd7)) begin
        sr_q   <= {sr_q[5:0], mosi_q[1]};
        bcnt_q <= bcnt_q + 3'd1;
        if (bcnt_q == 3'd7) begin
          byte_v_q  <= 1'b1;
          byte_q    <= {sr_q, mosi_q[1]};
          byte_dc_q <= dc_q[1];
        end
      end else if (csn_q[1]) begin
        bcnt_q <= '0;
      end
    end
  end

  logic [6:0] col_s_q, col_e_q;
  logic [5:0] row_s_q, row_e_q;
  logic       ld_x, ld_y;

`ifdef OLED_RX_WINDOW_EN
  typedef enum logic [2:0] {
    S_CMD, S_COL_S, S_COL_E, S_ROW_S, S_ROW_E
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] col_s_d, col_e_d;
  logic [5:0] row_s_d, row_e_d;

  function automatic logic [6:0] clamp_x(input logic [7:0] b);
    return (b > {1'b0, XMAX}) ? XMAX : b[6:0];
  endfunction

  function automatic logic [5:0] clamp_y(input logic [7:0] b);
    return (b > {2'b0, YMAX}) ? YMAX : b[5:0];
  endfunction

  always_ff @(posedge clk) begin
    if (frst) begin
      state_q <= S_CMD;
      col_s_q <= '0;
      col_e_q <= XMAX;
      row_s_q <= '0;
      row_e_q <= YMAX;
    end else begin
      state_q <= state_d;
      col_s_q <= col_s_d;
      col_e_q <= col_e_d;
      row_s_q <= row_s_d;
      row_e_q <= row_e_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_s_d = col_s_q;
    col_e_d = col_e_q;
    row_s_d = row_s_q;
    row_e_d = row_e_q;
    ld_x    = 1'b0;
    ld_y    = 1'b0;
    if (byte_v_q) begin
      if (byte_dc_q) begin
        state_d = S_CMD;
      end else begin
        unique case (state_q)
          S_CMD: begin
            if (byte_q == 8'h15) state_d = S_COL_S;
            else if (byte_q == 8'h75) state_d = S_ROW_S;
          end
          S_COL_S: begin
            col_s_d = clamp_x(byte_q);
            state_d = S_COL_E;
          end
          S_COL_E: begin
            col_e_d = clamp_x(byte_q);
            ld_x    = 1'b1;
            state_d = S_CMD;
          end
          S_ROW_S: begin
            row_s_d = clamp_y(byte_q);
            state_d = S_ROW_E;
          end
          S_ROW_E: begin
            row_e_d = clamp_y(byte_q);
            ld_y    = 1'b1;
            state_d = S_CMD;
          end
          default: state_d = S_CMD;
        endcase
      end
    end
  end
`else
  assign col_s_q = '0;
  assign col_e_q = XMAX;
  assign row_s_q = '0;
  assign row_e_q = YMAX;
  assign ld_x    = 1'b0;
  assign ld_y    = 1'b0;
`endif

  logic       phase_q, px_done;
  logic [7:0] hi_q;
  logic [6:0] x_q, x_d;
  logic [5:0] y_q, y_d;

  assign px_done = byte_v_q & byte_dc_q & phase_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (ld_x) x_d = col_s_q;
    if (ld_y) y_d = row_s_q;
    if (px_done) begin
      if (x_q == col_e_q) begin
        x_d = col_s_q;
        if (y_q == row_e_q) y_d = row_s_q;
        else if (y_q == YMAX) y_d = '0;
        else y_d = y_q + 6'd1;
      end else if (x_q == XMAX) begin
        x_d = '0;
      end else begin
        x_d = x_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (frst) begin
      phase_q   <= 1'b0;
      hi_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      cmd_valid <= 1'b0;
      cmd_data  <= '0;
      px_valid  <= 1'b0;
      px_x      <= '0;
      px_y      <= '0;
      px_color  <= '0;
      frame_end <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      cmd_valid <= 1'b0;
      px_valid  <= 1'b0;
      frame_end <= 1'b0;
      if (byte_v_q) begin
        if (!byte_dc_q) begin
          cmd_valid <= 1'b1;
          cmd_data  <= byte_q;
          phase_q   <= 1'b0;
        end else if (!phase_q) begin
          hi_q    <= byte_q;
          phase_q <= 1'b1;
        end else begin
          px_valid  <= 1'b1;
          px_color  <= {hi_q, byte_q};
          px_x      <= x_q;
          px_y      <= y_q;
          frame_end <= (x_q == col_e_q) && (y_q == row_e_q);
          phase_q   <= 1'b0;
        end
      end
    end
  end

endmodule
